// File: rtl/adder_pkg.sv
// Shared types for the serial adder/subtractor: the operation sequencer states.
package adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } sadd_state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/command and result handshake bundle for serial_adder.
interface serial_adder_if #(
    parameter int WIDTH = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full_adder cells; also exposes
// the carry entering the top bit so the caller can derive signed overflow.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout     = carry[DIGIT];
    assign c_msb_in = carry[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell; the building block of the digit ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands consumed DIGIT bits per cycle,
// least-significant digit first, with valid/ready handshakes on both sides.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(NDIG + 1);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_adder: illegal WIDTH/DIGIT combination");
    end

    sadd_state_t state;
    sadd_state_t next_state;

    logic [WIDTH-1:0]       opa;
    logic [WIDTH-1:0]       opb;
    logic [WIDTH-1:0]       sum_reg;
    logic                   carry;
    logic                   cout_reg;
    logic                   ovf_reg;
    logic                   in_ready_reg;
    logic                   out_valid_reg;
    logic [CNT_W-1:0]       dig_cnt;

    logic [DIGIT-1:0]       dig_sum;
    logic                   dig_cout;
    logic                   dig_c_msb;
    logic [WIDTH+DIGIT-1:0] sum_cat;

    logic                   accept;
    logic                   transfer;
    logic                   last_digit;

    assign accept     = bus.in_valid && in_ready_reg;
    assign transfer   = out_valid_reg && bus.out_ready;
    assign last_digit = (dig_cnt == CNT_W'(NDIG - 1));

    // New digit enters at the top; the concatenation keeps DIGIT==WIDTH legal.
    assign sum_cat = {dig_sum, sum_reg};

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a        (opa[DIGIT-1:0]),
        .b        (opb[DIGIT-1:0]),
        .cin      (carry),
        .sum      (dig_sum),
        .cout     (dig_cout),
        .c_msb_in (dig_c_msb)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state takes a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept)     next_state = S_BUSY;
            S_BUSY:  if (last_digit) next_state = S_DONE;
            S_DONE:  if (transfer)   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: these are individual flops rather than a memory array, so all of them take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa           <= '0;
            opb           <= '0;
            carry         <= 1'b0;
            dig_cnt       <= '0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            in_ready_reg  <= (next_state == S_IDLE);
            out_valid_reg <= (next_state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        opa     <= bus.a;
                        opb     <= bus.sub ? ~bus.b : bus.b;
                        carry   <= bus.cin ^ bus.sub;
                        dig_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    sum_reg <= sum_cat[WIDTH+DIGIT-1:DIGIT];
                    opa     <= opa >> DIGIT;
                    opb     <= opb >> DIGIT;
                    carry   <= dig_cout;
                    dig_cnt <= dig_cnt + CNT_W'(1);
                    if (last_digit) begin
                        cout_reg <= dig_cout;
                        ovf_reg  <= dig_c_msb ^ dig_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 with DIGIT in {1,2,4,8}; one DUT per DIGIT,
// a selector routes the shared stimulus to one of them at a time.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic       cin;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    int         sel;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    logic       m_in_ready;
    logic       m_out_valid;
    logic       m_cout;
    logic       m_ovf;
    logic [7:0] m_sum;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_if #(.WIDTH(8)) bus1 ();
    serial_adder_if #(.WIDTH(8)) bus2 ();
    serial_adder_if #(.WIDTH(8)) bus4 ();
    serial_adder_if #(.WIDTH(8)) bus8 ();

    assign bus1.in_valid = in_valid && (sel == 0);
    assign bus2.in_valid = in_valid && (sel == 1);
    assign bus4.in_valid = in_valid && (sel == 2);
    assign bus8.in_valid = in_valid && (sel == 3);
    assign bus1.a = a;  assign bus1.b = b;  assign bus1.cin = cin;  assign bus1.sub = sub;  assign bus1.out_ready = out_ready;
    assign bus2.a = a;  assign bus2.b = b;  assign bus2.cin = cin;  assign bus2.sub = sub;  assign bus2.out_ready = out_ready;
    assign bus4.a = a;  assign bus4.b = b;  assign bus4.cin = cin;  assign bus4.sub = sub;  assign bus4.out_ready = out_ready;
    assign bus8.a = a;  assign bus8.b = b;  assign bus8.cin = cin;  assign bus8.sub = sub;  assign bus8.out_ready = out_ready;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    always_comb begin
        m_in_ready  = bus4.in_ready;
        m_out_valid = bus4.out_valid;
        m_sum       = bus4.sum;
        m_cout      = bus4.cout;
        m_ovf       = bus4.ovf;
        case (sel)
            0: begin m_in_ready = bus1.in_ready; m_out_valid = bus1.out_valid; m_sum = bus1.sum; m_cout = bus1.cout; m_ovf = bus1.ovf; end
            1: begin m_in_ready = bus2.in_ready; m_out_valid = bus2.out_valid; m_sum = bus2.sum; m_cout = bus2.cout; m_ovf = bus2.ovf; end
            3: begin m_in_ready = bus8.in_ready; m_out_valid = bus8.out_valid; m_sum = bus8.sum; m_cout = bus8.cout; m_ovf = bus8.ovf; end
            default: ;
        endcase
    end

    // Called at a negedge; returns at the negedge after the accept edge with in_valid dropped.
    task automatic accept_op(input logic [7:0] op_a, input logic [7:0] op_b,
                             input logic op_cin, input logic op_sub, output bit timed_out);
        int n;
        timed_out = 1'b0;
        a = op_a; b = op_b; cin = op_cin; sub = op_sub; in_valid = 1'b1;
        n = 0;
        while (!m_in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!m_in_ready) begin
            timed_out = 1'b1;
            in_valid  = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    // Counts clock edges after the accept edge until out_valid is seen (sampled at negedges).
    task automatic wait_valid(output int lat, output bit timed_out);
        lat = 0;
        while (!m_out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        timed_out = !m_out_valid;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        sel = 2; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (m_in_ready !== 1'b0)  begin failures++; $display("FAIL reset_in_ready got=%0b want=0", m_in_ready); end
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want=0", m_out_valid); end
        checks++; if (m_sum !== 8'h00)      begin failures++; $display("FAIL reset_sum got=%02h want=00", m_sum); end
        checks++; if (m_cout !== 1'b0)      begin failures++; $display("FAIL reset_cout got=%0b want=0", m_cout); end
        checks++; if (m_ovf !== 1'b0)       begin failures++; $display("FAIL reset_ovf got=%0b want=0", m_ovf); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (m_in_ready !== 1'b1)  begin failures++; $display("FAIL release_in_ready got=%0b want=1", m_in_ready); end
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid got=%0b want=0", m_out_valid); end
    endtask

    typedef struct {
        logic [7:0] op_a;
        logic [7:0] op_b;
        logic       op_cin;
        logic       op_sub;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    task automatic test_arith();
        vec_t vecs[5];
        int   lat;
        bit   to;
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        sel = 2;
        foreach (vecs[i]) begin
            accept_op(vecs[i].op_a, vecs[i].op_b, vecs[i].op_cin, vecs[i].op_sub, to);
            if (!to) wait_valid(lat, to);
            checks++;
            if (to) begin
                failures++; $display("FAIL arith_timeout vec=%0d got=no_result want=result", i);
                continue;
            end
            checks++; if (lat != 2) begin failures++; $display("FAIL arith_latency vec=%0d got=%0d want=2", i, lat); end
            checks++; if (m_sum !== vecs[i].exp_sum)   begin failures++; $display("FAIL arith_sum vec=%0d got=%02h want=%02h", i, m_sum, vecs[i].exp_sum); end
            checks++; if (m_cout !== vecs[i].exp_cout) begin failures++; $display("FAIL arith_cout vec=%0d got=%0b want=%0b", i, m_cout, vecs[i].exp_cout); end
            checks++; if (m_ovf !== vecs[i].exp_ovf)   begin failures++; $display("FAIL arith_ovf vec=%0d got=%0b want=%0b", i, m_ovf, vecs[i].exp_ovf); end
            release_result();
            checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL arith_drop_valid vec=%0d got=%0b want=0", i, m_out_valid); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        sel = 2;
        accept_op(8'h3C, 8'h5A, 1'b0, 1'b0, to);
        // Competing command held through BUSY and DONE; must be ignored.
        a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b1; in_valid = 1'b1;
        if (!to) wait_valid(lat, to);
        checks++;
        if (to) begin
            failures++; $display("FAIL bp_timeout got=no_result want=result");
            in_valid = 1'b0;
            return;
        end
        for (int k = 0; k < 5; k++) begin
            checks++; if (m_sum !== 8'h96)      begin failures++; $display("FAIL bp_sum cyc=%0d got=%02h want=96", k, m_sum); end
            checks++; if (m_cout !== 1'b0)      begin failures++; $display("FAIL bp_cout cyc=%0d got=%0b want=0", k, m_cout); end
            checks++; if (m_ovf !== 1'b1)       begin failures++; $display("FAIL bp_ovf cyc=%0d got=%0b want=1", k, m_ovf); end
            checks++; if (m_out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%0b want=1", k, m_out_valid); end
            checks++; if (m_in_ready !== 1'b0)  begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%0b want=0", k, m_in_ready); end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL bp_after_out_valid got=%0b want=0", m_out_valid); end
        checks++; if (m_in_ready !== 1'b1)  begin failures++; $display("FAIL bp_after_in_ready got=%0b want=1", m_in_ready); end
        repeat (3) @(negedge clk);
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_extra_op got=%0b want=0", m_out_valid); end
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        bit to;
        sel = 2;
        accept_op(8'hAA, 8'h11, 1'b0, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL rst_accept_timeout got=no_accept want=accept"); end
        rst_n = 1'b0;
        #1;
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL rst_busy_out_valid got=%0b want=0", m_out_valid); end
        checks++; if (m_sum !== 8'h00)      begin failures++; $display("FAIL rst_busy_sum got=%02h want=00", m_sum); end
        checks++; if (m_in_ready !== 1'b0)  begin failures++; $display("FAIL rst_busy_in_ready got=%0b want=0", m_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (m_in_ready !== 1'b1)  begin failures++; $display("FAIL rst_release_in_ready got=%0b want=1", m_in_ready); end
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL rst_release_out_valid got=%0b want=0", m_out_valid); end
        checks++; if (m_sum !== 8'h00)      begin failures++; $display("FAIL rst_release_sum got=%02h want=00", m_sum); end
        accept_op(8'h12, 8'h34, 1'b0, 1'b0, to);
        if (!to) wait_valid(lat, to);
        checks++;
        if (to) begin
            failures++; $display("FAIL rst_next_timeout got=no_result want=result");
            return;
        end
        checks++; if (lat != 2)        begin failures++; $display("FAIL rst_next_latency got=%0d want=2", lat); end
        checks++; if (m_sum !== 8'h46) begin failures++; $display("FAIL rst_next_sum got=%02h want=46", m_sum); end
        checks++; if (m_cout !== 1'b0) begin failures++; $display("FAIL rst_next_cout got=%0b want=0", m_cout); end
        checks++; if (m_ovf !== 1'b0)  begin failures++; $display("FAIL rst_next_ovf got=%0b want=0", m_ovf); end
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals[12];
        logic [7:0] esum;
        logic       ecout;
        logic       eovf;
        int         ures, sres, ndig, lat, prev_acc;
        bit         to, first;
        vals = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h10, 8'h55, 8'h7E, 8'h7F, 8'h80, 8'h81, 8'hAA, 8'hFF};
        out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel      = s;
            ndig     = 8 >> s;
            first    = 1'b1;
            prev_acc = 0;
            @(negedge clk);
            for (int i = 0; i < 12; i++) begin
                for (int j = 0; j < 12; j++) begin
                    for (int c = 0; c < 2; c++) begin
                        for (int m = 0; m < 2; m++) begin
                            accept_op(vals[i], vals[j], c[0], m[0], to);
                            if (!to) wait_valid(lat, to);
                            checks++;
                            if (to) begin
                                failures++;
                                $display("FAIL sweep_timeout digit=%0d a=%02h b=%02h got=no_result want=result", 1 << s, vals[i], vals[j]);
                                continue;
                            end
                            if (m == 1) begin
                                ures  = int'(vals[i]) - int'(vals[j]) - c;
                                sres  = int'($signed(vals[i])) - int'($signed(vals[j])) - c;
                                ecout = (ures >= 0);
                            end else begin
                                ures  = int'(vals[i]) + int'(vals[j]) + c;
                                sres  = int'($signed(vals[i])) + int'($signed(vals[j])) + c;
                                ecout = (ures > 255);
                            end
                            esum = ures[7:0];
                            eovf = (sres > 127) || (sres < -128);
                            checks++; if (lat != ndig) begin failures++; $display("FAIL sweep_latency digit=%0d got=%0d want=%0d", 1 << s, lat, ndig); end
                            if (!first) begin
                                checks++;
                                if (acc_cyc - prev_acc != ndig + 2) begin
                                    failures++; $display("FAIL sweep_period digit=%0d got=%0d want=%0d", 1 << s, acc_cyc - prev_acc, ndig + 2);
                                end
                            end
                            checks++; if (m_sum !== esum)   begin failures++; $display("FAIL sweep_sum digit=%0d a=%02h b=%02h cin=%0d sub=%0d got=%02h want=%02h", 1 << s, vals[i], vals[j], c, m, m_sum, esum); end
                            checks++; if (m_cout !== ecout) begin failures++; $display("FAIL sweep_cout digit=%0d a=%02h b=%02h cin=%0d sub=%0d got=%0b want=%0b", 1 << s, vals[i], vals[j], c, m, m_cout, ecout); end
                            checks++; if (m_ovf !== eovf)   begin failures++; $display("FAIL sweep_ovf digit=%0d a=%02h b=%02h cin=%0d sub=%0d got=%0b want=%0b", 1 << s, vals[i], vals[j], c, m, m_ovf, eovf); end
                            prev_acc = acc_cyc;
                            first    = 1'b0;
                        end
                    end
                end
            end
            repeat (2) @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired before the summary was reached");
        $fatal(1, "watchdog");
    end

endmodule
